// File: rtl/arm_pkg.sv
// Shared widths, ALU command encodings and status-flag indices
// for the ARM core pipeline.
package arm_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CMD_W      = 4;

  localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
  localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [3:0] EXE_CMD_AND = 4'b0110;
  localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [3:0] EXE_CMD_EOR = 4'b1000;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic mem_r_en;
    logic mem_w_en;
    logic wb_en;
    logic b;
    logic s;
  } ctrl_t;

endpackage

// File: rtl/pipe_field_reg.sv
// Async-reset register group with load enable and synchronous clear.
// Clear only takes effect on enabled edges, so a held stage keeps its value.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: hold > flush > bubble > load per edge.
// Bubbles kill control only; data still loads for stable forwarding.
module id_ex_reg
  import arm_pkg::*;
#(
  parameter int DATA_W     = arm_pkg::DATA_W,
  parameter int REG_ADDR_W = arm_pkg::REG_ADDR_W,
  parameter int CMD_W      = arm_pkg::CMD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [CMD_W-1:0]      exe_cmd_in,
  input  logic                  mem_R_en_in,
  input  logic                  mem_W_en_in,
  input  logic                  WB_en_in,
  input  logic                  B_in,
  input  logic                  S_in,
  input  logic [3:0]            sr_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [CMD_W-1:0]      exe_cmd_out,
  output logic                  mem_R_en_out,
  output logic                  mem_W_en_out,
  output logic                  WB_en_out,
  output logic                  B_out,
  output logic                  S_out,
  output logic [3:0]            sr_out,
  output logic                  valid_out
);

  localparam int DW = 3*DATA_W + 1 + 12 + 24
                    + 3*REG_ADDR_W + CMD_W + 4;
  localparam int CW = $bits(ctrl_t) + 1;

  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  logic [CW-1:0] ctrl_d;
  logic [CW-1:0] ctrl_q;
  ctrl_t         ctrl_in;
  ctrl_t         ctrl_out;
  logic          illegal;
  logic          load_en;
  logic          ctrl_clr;

  assign load_en = !hold;

  // Read and write together is an undecodable op; treat it as a NOP.
  assign illegal  = mem_R_en_in & mem_W_en_in;
  assign ctrl_clr = flush | bubble | illegal;

  assign data_d = {pc_in, val_rn_in, val_rm_in, imm_in,
                   shift_operand_in, signed_imm24_in,
                   dest_in, src1_in, src2_in,
                   exe_cmd_in, sr_in};

  assign {pc_out, val_rn_out, val_rm_out, imm_out,
          shift_operand_out, signed_imm24_out,
          dest_out, src1_out, src2_out,
          exe_cmd_out, sr_out} = data_q;

  assign ctrl_in.mem_r_en = mem_R_en_in;
  assign ctrl_in.mem_w_en = mem_W_en_in;
  assign ctrl_in.wb_en    = WB_en_in;
  assign ctrl_in.b        = B_in;
  assign ctrl_in.s        = S_in;

  assign ctrl_d = {ctrl_in, 1'b1};

  assign ctrl_out     = ctrl_t'(ctrl_q[CW-1:1]);
  assign valid_out    = ctrl_q[0];
  assign mem_R_en_out = ctrl_out.mem_r_en;
  assign mem_W_en_out = ctrl_out.mem_w_en;
  assign WB_en_out    = ctrl_out.wb_en;
  assign B_out        = ctrl_out.b;
  assign S_out        = ctrl_out.s;

  pipe_field_reg #(.W(DW)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (flush),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_field_reg #(.W(CW)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .clr (ctrl_clr),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a behavioural model predicts
// each edge, expectations are queued and popped after the edge.
module tb_id_ex_reg;
  import arm_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic [3:0]  sr;
  } fields_t;

  typedef struct packed {
    fields_t f;
    logic    v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hold, flush, bubble;
  fields_t in_b;
  fields_t out_f;
  logic    out_v;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, sr_out;
  logic        mem_R_en_out, mem_W_en_out, WB_en_out, B_out, S_out;

  assign out_f = '{pc_out, val_rn_out, val_rm_out, imm_out,
                   shift_operand_out, signed_imm24_out,
                   dest_out, src1_out, src2_out, exe_cmd_out,
                   mem_R_en_out, mem_W_en_out, WB_en_out,
                   B_out, S_out, sr_out};

  id_ex_reg dut (
    .clk               (clk),
    .rst               (rst),
    .hold              (hold),
    .flush             (flush),
    .bubble            (bubble),
    .pc_in             (in_b.pc),
    .val_rn_in         (in_b.val_rn),
    .val_rm_in         (in_b.val_rm),
    .imm_in            (in_b.imm),
    .shift_operand_in  (in_b.shift),
    .signed_imm24_in   (in_b.simm),
    .dest_in           (in_b.dest),
    .src1_in           (in_b.src1),
    .src2_in           (in_b.src2),
    .exe_cmd_in        (in_b.cmd),
    .mem_R_en_in       (in_b.mr),
    .mem_W_en_in       (in_b.mw),
    .WB_en_in          (in_b.wb),
    .B_in              (in_b.b),
    .S_in              (in_b.s),
    .sr_in             (in_b.sr),
    .pc_out            (pc_out),
    .val_rn_out        (val_rn_out),
    .val_rm_out        (val_rm_out),
    .imm_out           (imm_out),
    .shift_operand_out (shift_operand_out),
    .signed_imm24_out  (signed_imm24_out),
    .dest_out          (dest_out),
    .src1_out          (src1_out),
    .src2_out          (src2_out),
    .exe_cmd_out       (exe_cmd_out),
    .mem_R_en_out      (mem_R_en_out),
    .mem_W_en_out      (mem_W_en_out),
    .WB_en_out         (WB_en_out),
    .B_out             (B_out),
    .S_out             (S_out),
    .sr_out            (sr_out),
    .valid_out         (out_v)
  );

  int checks = 0;
  int errors = 0;
  exp_t model;
  exp_t sb[$];

  function automatic exp_t predict(exp_t cur);
    exp_t n;
    n = cur;
    if (hold) return n;
    if (flush) return '0;
    n.f = in_b;
    n.v = 1'b1;
    if (bubble || (in_b.mr && in_b.mw)) begin
      n.f.mr = 1'b0;
      n.f.mw = 1'b0;
      n.f.wb = 1'b0;
      n.f.b  = 1'b0;
      n.f.s  = 1'b0;
      n.v    = 1'b0;
    end
    return n;
  endfunction

  task automatic cycle();
    model = predict(model);
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  function automatic fields_t rnd_fields();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(),
         $urandom(), $urandom()};
    return fields_t'(r[157:0]);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    hold = 0; flush = 0; bubble = 0;
    in_b = rnd_fields();
    model = '0;
    @(posedge clk);
    #1;
    sb.push_back(model);
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL reset_init got %h want %h", {out_f, out_v}, e);
    end
    rst = 1'b0;
    in_b = rnd_fields();
    in_b.mw = 1'b0;
    cycle();
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL reset_release got %h want %h", {out_f, out_v}, e);
    end
    #2;
    rst = 1'b1;
    #1;
    model = '0;
    sb.push_back(model);
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL reset_async got %h want %h", {out_f, out_v}, e);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_load();
    exp_t e;
    in_b = '0;
    in_b.pc = 32'h14;
    in_b.val_rm = 32'hFF;
    in_b.imm = 1'b1;
    in_b.shift = 12'h20F;
    in_b.wb = 1'b1;
    cycle();
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL load got %h want %h", {out_f, out_v}, e);
    end
    checks++;
    if (pc_out !== 32'h14 || val_rm_out !== 32'hFF
        || shift_operand_out !== 12'h20F || out_v !== 1'b1) begin
      errors++;
      $display("FAIL load_fields pc %h rm %h sh %h v %b want 14 ff 20f 1",
               pc_out, val_rm_out, shift_operand_out, out_v);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_b = rnd_fields();
      cycle();
      e = sb.pop_front();
      checks++;
      if ({out_f, out_v} !== e || pc_out !== 32'h14) begin
        errors++;
        $display("FAIL hold%0d got %h want %h", i, {out_f, out_v}, e);
      end
    end
    hold = 1'b0;
    in_b = rnd_fields();
    in_b.mw = 1'b0;
    cycle();
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL hold_release got %h want %h", {out_f, out_v}, e);
    end
  endtask

  task automatic test_bubble();
    exp_t e;
    bubble = 1'b1;
    in_b = rnd_fields();
    in_b.dest = 4'd5;
    in_b.mr = 1'b1;
    in_b.mw = 1'b0;
    in_b.wb = 1'b1;
    cycle();
    bubble = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e) begin
      errors++;
      $display("FAIL bubble got %h want %h", {out_f, out_v}, e);
    end
    checks++;
    if (dest_out !== 4'd5 || mem_R_en_out !== 1'b0
        || WB_en_out !== 1'b0 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL bubble_fields dest %0d mr %b wb %b v %b want 5 0 0 0",
               dest_out, mem_R_en_out, WB_en_out, out_v);
    end
  endtask

  task automatic test_flush();
    exp_t e;
    in_b = rnd_fields();
    in_b.mw = 1'b0;
    in_b.wb = 1'b1;
    cycle();
    void'(sb.pop_front());
    flush = 1'b1;
    bubble = 1'b1;
    in_b = rnd_fields();
    cycle();
    bubble = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e || {out_f, out_v} !== '0) begin
      errors++;
      $display("FAIL flush_bubble got %h want %h", {out_f, out_v}, e);
    end
    flush = 1'b0;
    in_b = rnd_fields();
    in_b.mw = 1'b0;
    cycle();
    void'(sb.pop_front());
    flush = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_b = rnd_fields();
      cycle();
      e = sb.pop_front();
      checks++;
      if ({out_f, out_v} !== e || out_v !== 1'b1) begin
        errors++;
        $display("FAIL flush_held%0d got %h want %h", i, {out_f, out_v}, e);
      end
    end
    hold = 1'b0;
    cycle();
    flush = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e || {out_f, out_v} !== '0) begin
      errors++;
      $display("FAIL flush_after_hold got %h want %h", {out_f, out_v}, e);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    in_b = rnd_fields();
    in_b.mr = 1'b1;
    in_b.mw = 1'b1;
    in_b.wb = 1'b1;
    cycle();
    e = sb.pop_front();
    checks++;
    if ({out_f, out_v} !== e || mem_R_en_out !== 1'b0
        || mem_W_en_out !== 1'b0 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL illegal_mem got %h want %h", {out_f, out_v}, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      in_b = rnd_fields();
      hold   = ($urandom_range(0, 4) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      bubble = ($urandom_range(0, 4) == 0);
      cycle();
      e = sb.pop_front();
      checks++;
      if ({out_f, out_v} !== e) begin
        errors++;
        $display("FAIL b2b%0d got %h want %h", i, {out_f, out_v}, e);
      end
    end
    hold = 0; flush = 0; bubble = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_bubble();
    test_flush();
    test_illegal();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
